// File: rtl/ram_sync_nr1w_if.sv
// ram_sync_nr1w_if
// Bus bundle for ram_sync_nr1w: N read ports plus one bit-maskable write port.
//   rd_en    [RD_PORTS]          per-port read request
//   rd_addr  [RD_PORTS*64]       per-port byte address, port i at [64i+63:64i]
//   rd_data  [RD_PORTS*DATA_W]   per-port registered read data
//   rd_valid [RD_PORTS]          per-port read data valid
//   rd_err   [RD_PORTS]          per-port out-of-range flag (qualified by rd_valid)
//   wr_en, wr_addr, wr_data, wr_mask   write request, byte address, data, bit mask
//   wr_err                       one-cycle pulse for a dropped out-of-range write
// master = requester side, slave = memory side.
interface ram_sync_nr1w_if #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned RD_PORTS = 2
);
    logic [RD_PORTS-1:0]        rd_en;
    logic [RD_PORTS*64-1:0]     rd_addr;
    logic [RD_PORTS*DATA_W-1:0] rd_data;
    logic [RD_PORTS-1:0]        rd_valid;
    logic [RD_PORTS-1:0]        rd_err;
    logic                       wr_en;
    logic [63:0]                wr_addr;
    logic [DATA_W-1:0]          wr_data;
    logic [DATA_W-1:0]          wr_mask;
    logic                       wr_err;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_mask,
        input  rd_data, rd_valid, rd_err, wr_err
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_mask,
        output rd_data, rd_valid, rd_err, wr_err
    );
endinterface

// File: rtl/ram_sync_nr1w.sv
// ram_sync_nr1w
// Synchronous RAM, RD_PORTS registered read ports and one bit-maskable write
// port, mapped at BASE_ADDR. After reset the array is swept to zero; init_done
// rises when the sweep completes and requests are ignored until then.
// Reads have one cycle latency with write-first forwarding. Port 0 can return
// a zero-extended 32-bit lane selected by addr[2] (instruction fetch).
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset (restarts the clear sweep)
//   init_done  high once the clear sweep has completed
//   bus        ram_sync_nr1w_if.slave read/write bundle
module ram_sync_nr1w #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned DEPTH      = 4096,
    parameter int unsigned RD_PORTS   = 2,
    parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000,
    parameter bit          RD0_NARROW = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             init_done,
    ram_sync_nr1w_if.slave   bus
);
    localparam int unsigned BYTE_SHIFT = $clog2(DATA_W / 8);
    localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit          NARROW     = RD0_NARROW && (DATA_W == 64);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // In range only above the base and below the top; the wrapping subtract
    // makes addresses below the base look huge, the explicit compare keeps
    // that independent of the shift.
    function automatic logic addr_ok(input logic [63:0] addr);
        logic [63:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && ((off >> BYTE_SHIFT) < 64'(DEPTH));
    endfunction

    function automatic logic [AW-1:0] addr_idx(input logic [63:0] addr);
        logic [63:0] off;
        off = addr - BASE_ADDR;
        return off[BYTE_SHIFT +: AW];
    endfunction

    state_t                     state_r;
    state_t                     state_nxt_s;
    logic [AW-1:0]              cnt_r;
    logic                       init_done_r;
    logic [DATA_W-1:0]          mem_r [DEPTH];

    logic                       run_s;
    logic                       wr_ok_s;
    logic                       wr_fire_s;
    logic [AW-1:0]              wr_idx_s;
    logic [DATA_W-1:0]          wr_merged_s;

    logic                       rd_ok_s   [RD_PORTS];
    logic [DATA_W-1:0]          rd_word_s [RD_PORTS];

    logic [RD_PORTS*DATA_W-1:0] rd_data_r;
    logic [RD_PORTS-1:0]        rd_valid_r;
    logic [RD_PORTS-1:0]        rd_err_r;
    logic                       wr_err_r;

    assign run_s        = (state_r == ST_RUN);
    assign init_done    = init_done_r;
    assign bus.rd_data  = rd_data_r;
    assign bus.rd_valid = rd_valid_r;
    assign bus.rd_err   = rd_err_r;
    assign bus.wr_err   = wr_err_r;

    // Next-state logic: the sweep finishes after clearing the last index.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (cnt_r == AW'(DEPTH - 1)) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_INIT;
        endcase
    end

    // State register, clear counter and init_done flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_INIT;
            cnt_r       <= '0;
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= (state_r == ST_INIT) ? cnt_r + AW'(1) : cnt_r;
            init_done_r <= (state_nxt_s == ST_RUN);
        end
    end

    // Write decode; the merged word also feeds same-cycle read forwarding.
    always_comb begin
        wr_ok_s     = addr_ok(bus.wr_addr);
        wr_idx_s    = addr_idx(bus.wr_addr);
        wr_merged_s = (mem_r[wr_idx_s] & ~bus.wr_mask) | (bus.wr_data & bus.wr_mask);
        wr_fire_s   = run_s && bus.wr_en && wr_ok_s;
    end

    // Array write: clear sweep during INIT, masked user write during RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_r == ST_INIT) begin
                mem_r[cnt_r] <= '0;
            end else if (wr_fire_s) begin
                mem_r[wr_idx_s] <= wr_merged_s;
            end
        end
    end

    // Per-port read decode: range check, forwarding and port-0 lane select.
    always_comb begin : rd_decode
        logic [63:0]       a_v;
        logic [AW-1:0]     idx_v;
        logic [DATA_W-1:0] w_v;
        logic [31:0]       lane_v;
        for (int i = 0; i < int'(RD_PORTS); i++) begin
            a_v   = bus.rd_addr[64*i +: 64];
            idx_v = addr_idx(a_v);
            rd_ok_s[i] = addr_ok(a_v);
            if (wr_fire_s && (idx_v == wr_idx_s)) begin
                w_v = wr_merged_s;
            end else begin
                w_v = mem_r[idx_v];
            end
            lane_v = a_v[2] ? w_v[DATA_W-1 -: 32] : w_v[31:0];
            if (!rd_ok_s[i]) begin
                rd_word_s[i] = '0;
            end else if ((i == 0) && NARROW) begin
                rd_word_s[i] = DATA_W'(lane_v);
            end else begin
                rd_word_s[i] = w_v;
            end
        end
    end

    // Registered read outputs and write-error pulse; data holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r  <= '0;
            rd_valid_r <= '0;
            rd_err_r   <= '0;
            wr_err_r   <= 1'b0;
        end else begin
            for (int i = 0; i < int'(RD_PORTS); i++) begin
                if (run_s && bus.rd_en[i]) begin
                    rd_valid_r[i]              <= 1'b1;
                    rd_err_r[i]                <= !rd_ok_s[i];
                    rd_data_r[DATA_W*i +: DATA_W] <= rd_word_s[i];
                end else begin
                    rd_valid_r[i] <= 1'b0;
                    rd_err_r[i]   <= 1'b0;
                end
            end
            wr_err_r <= run_s && bus.wr_en && !wr_ok_s;
        end
    end
endmodule

// File: tb/tb_ram_sync_nr1w.sv
// tb_ram_sync_nr1w
// Directed bench for ram_sync_nr1w with DEPTH=16, two read ports, narrow port 0.
module tb_ram_sync_nr1w;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned NP     = 2;
    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk;
    logic rst;
    logic init_done;
    int   n_checks;
    int   n_errors;

    ram_sync_nr1w_if #(.DATA_W(DATA_W), .RD_PORTS(NP)) bus_if ();

    ram_sync_nr1w #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_PORTS(NP),
        .BASE_ADDR(64'h0000_0000_8000_0000), .RD0_NARROW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .init_done(init_done), .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [1:0] en, input logic [63:0] a0, input logic [63:0] a1);
        bus_if.rd_en   = en;
        bus_if.rd_addr = {a1, a0};
    endtask

    task automatic set_wr(input logic en, input logic [63:0] a, input logic [63:0] d, input logic [63:0] m);
        bus_if.wr_en   = en;
        bus_if.wr_addr = a;
        bus_if.wr_data = d;
        bus_if.wr_mask = m;
    endtask

    function automatic logic [63:0] rd(input int p);
        return bus_if.rd_data[64*p +: 64];
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        set_rd(2'b00, 64'h0, 64'h0);
        set_wr(1'b0, 64'h0, 64'h0, 64'h0);
        repeat (3) tick();

        // Reset state
        check_eq("rst_init_done", {63'd0, init_done}, 64'd0);
        check_eq("rst_rd_valid", {62'd0, bus_if.rd_valid}, 64'd0);
        check_eq("rst_rd_err", {62'd0, bus_if.rd_err}, 64'd0);
        check_eq("rst_rd_data", bus_if.rd_data[63:0] | bus_if.rd_data[127:64], 64'd0);
        check_eq("rst_wr_err", {63'd0, bus_if.wr_err}, 64'd0);

        // Sweep: requests during INIT are ignored, including this write
        rst = 1'b0;
        set_rd(2'b11, 64'h8000_0000, 64'h8000_0008);
        set_wr(1'b1, 64'h8000_0000, ONES, ONES);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 15) check_eq("sweep_init_done_k15", {63'd0, init_done}, 64'd0);
            if (k == 16) check_eq("sweep_init_done_k16", {63'd0, init_done}, 64'd1);
            check_eq("sweep_no_rd_valid", {62'd0, bus_if.rd_valid}, 64'd0);
            check_eq("sweep_no_wr_err", {63'd0, bus_if.wr_err}, 64'd0);
        end
        set_wr(1'b0, 64'h0, 64'h0, 64'h0);

        // Cleared contents read back as zero
        set_rd(2'b11, 64'h8000_0000, 64'h8000_0078);
        tick();
        check_eq("clr_valid", {62'd0, bus_if.rd_valid}, 64'd3);
        check_eq("clr_data0", rd(0), 64'd0);
        check_eq("clr_data1", rd(1), 64'd0);
        check_eq("clr_err", {62'd0, bus_if.rd_err}, 64'd0);

        // Masked write
        set_rd(2'b00, 64'h0, 64'h0);
        set_wr(1'b1, 64'h8000_0008, ONES, ONES);
        tick();
        set_wr(1'b1, 64'h8000_0008, 64'h1234, 64'hFFFF);
        tick();
        set_wr(1'b0, 64'h0, 64'h0, 64'h0);
        set_rd(2'b10, 64'h0, 64'h8000_0008);
        tick();
        check_eq("mask_data", rd(1), 64'hFFFF_FFFF_FFFF_1234);
        check_eq("mask_valid", {62'd0, bus_if.rd_valid}, 64'd2);
        set_rd(2'b00, 64'h0, 64'h0);
        tick();
        check_eq("idle_valid", {62'd0, bus_if.rd_valid}, 64'd0);
        check_eq("idle_hold", rd(1), 64'hFFFF_FFFF_FFFF_1234);

        // Forwarding on both ports, port 0 narrow
        set_wr(1'b1, 64'h8000_0010, 64'hA5A5, ONES);
        set_rd(2'b11, 64'h8000_0010, 64'h8000_0010);
        tick();
        set_wr(1'b0, 64'h0, 64'h0, 64'h0);
        set_rd(2'b00, 64'h0, 64'h0);
        check_eq("fwd_data1", rd(1), 64'hA5A5);
        check_eq("fwd_data0", rd(0), 64'hA5A5);
        check_eq("fwd_valid", {62'd0, bus_if.rd_valid}, 64'd3);

        // Narrow fetch
        set_wr(1'b1, 64'h8000_0000, 64'hDEADBEEF_CAFEF00D, ONES);
        tick();
        set_wr(1'b0, 64'h0, 64'h0, 64'h0);
        set_rd(2'b11, 64'h8000_0004, 64'h8000_0000);
        tick();
        check_eq("narrow_hi", rd(0), 64'h0000_0000_DEAD_BEEF);
        check_eq("wide_word", rd(1), 64'hDEADBEEF_CAFEF00D);
        set_rd(2'b01, 64'h8000_0000, 64'h0);
        tick();
        check_eq("narrow_lo", rd(0), 64'h0000_0000_CAFE_F00D);

        // Range errors
        set_rd(2'b11, 64'h7FFF_FFF8, 64'h8000_0080);
        tick();
        check_eq("oor_err", {62'd0, bus_if.rd_err}, 64'd3);
        check_eq("oor_data0", rd(0), 64'd0);
        check_eq("oor_data1", rd(1), 64'd0);
        check_eq("oor_valid", {62'd0, bus_if.rd_valid}, 64'd3);
        set_rd(2'b00, 64'h0, 64'h0);
        set_wr(1'b1, 64'h7FFF_FFF8, ONES, ONES);
        tick();
        check_eq("wr_err_pulse", {63'd0, bus_if.wr_err}, 64'd1);
        set_wr(1'b0, 64'h0, 64'h0, 64'h0);
        set_rd(2'b10, 64'h0, 64'h8000_0078);
        tick();
        check_eq("wr_err_clear", {63'd0, bus_if.wr_err}, 64'd0);
        check_eq("oor_no_alias", rd(1), 64'd0);
        set_rd(2'b10, 64'h0, 64'h8000_0000);
        tick();
        check_eq("oor_mem_kept", rd(1), 64'hDEADBEEF_CAFEF00D);
        set_rd(2'b00, 64'h0, 64'h0);

        // Mid-operation reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_drop", {63'd0, init_done}, 64'd0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 15) check_eq("mid_init_done_k15", {63'd0, init_done}, 64'd0);
            if (k == 16) check_eq("mid_init_done_k16", {63'd0, init_done}, 64'd1);
        end
        set_rd(2'b11, 64'h8000_0008, 64'h8000_0000);
        tick();
        check_eq("mid_clr_data0", rd(0), 64'd0);
        check_eq("mid_clr_data1", rd(1), 64'd0);
        check_eq("mid_clr_valid", {62'd0, bus_if.rd_valid}, 64'd3);
        set_rd(2'b00, 64'h0, 64'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
